// File: rtl/logic_arbiter_pkg.sv
// Shared definitions for the logical unit and its two-port arbiter.
package logic_arbiter_pkg;

    // Funct codes, interpreted against is_branch.
    // Logical ops (is_branch = 0).
    localparam logic [3:0] FUNCT3_SLT  = 4'h2;
    localparam logic [3:0] FUNCT3_SLTU = 4'h3;
    localparam logic [3:0] FUNCT3_XOR  = 4'h4;
    localparam logic [3:0] FUNCT3_OR   = 4'h6;
    localparam logic [3:0] FUNCT3_AND  = 4'h7;
    // Branch compares (is_branch = 1).
    localparam logic [3:0] FUNCT3_BEQ  = 4'h0;
    localparam logic [3:0] FUNCT3_BNE  = 4'h1;
    localparam logic [3:0] FUNCT3_BLT  = 4'h4;
    localparam logic [3:0] FUNCT3_BGE  = 4'h5;
    localparam logic [3:0] FUNCT3_BLTU = 4'h6;
    localparam logic [3:0] FUNCT3_BGEU = 4'h7;

    localparam int unsigned LOGIC_TAG_W = 4;

    typedef struct packed {
        logic [3:0]             funct;
        logic                   is_branch;
        logic [31:0]            op1;
        logic [31:0]            op2;
        logic [LOGIC_TAG_W-1:0] tag;
    } logic_req_t;

    typedef struct packed {
        logic [31:0]            result;
        logic                   taken;
        logic                   id;
        logic [LOGIC_TAG_W-1:0] tag;
    } logic_rsp_t;

endpackage

// File: rtl/logical.sv
// Combinational compare / bitwise unit. Undefined funct codes yield zero.
module logical
    import logic_arbiter_pkg::*;
(
    input  logic [3:0]  funct_i,
    input  logic        is_branch_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    output logic [31:0] result_o,
    output logic        taken_o
);

    // Decode funct into either a branch decision or a logical result.
    always_comb begin
        result_o = '0;
        taken_o  = 1'b0;
        if (is_branch_i) begin
            case (funct_i)
                FUNCT3_BEQ:  taken_o = (op1_i == op2_i);
                FUNCT3_BNE:  taken_o = (op1_i != op2_i);
                FUNCT3_BLT:  taken_o = ($signed(op1_i) < $signed(op2_i));
                FUNCT3_BGE:  taken_o = ($signed(op1_i) >= $signed(op2_i));
                FUNCT3_BLTU: taken_o = (op1_i < op2_i);
                FUNCT3_BGEU: taken_o = (op1_i >= op2_i);
                default:     taken_o = 1'b0;
            endcase
        end else begin
            case (funct_i)
                FUNCT3_SLT:  result_o = {31'b0, ($signed(op1_i) < $signed(op2_i))};
                FUNCT3_SLTU: result_o = {31'b0, (op1_i < op2_i)};
                FUNCT3_XOR:  result_o = op1_i ^ op2_i;
                FUNCT3_OR:   result_o = op1_i | op2_i;
                FUNCT3_AND:  result_o = op1_i & op2_i;
                default:     result_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/logic_arbiter.sv
// Round-robin arbiter sharing one logical unit between the ALU (port 0) and
// the branch-resolution path (port 1), with a one-entry registered response.
module logic_arbiter
    import logic_arbiter_pkg::*;
#(
    // Must equal LOGIC_TAG_W; the response struct carries a tag of that width.
    parameter int unsigned TAG_W = LOGIC_TAG_W
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [1:0][3:0]       req_funct_i,
    input  logic [1:0]            req_is_branch_i,
    input  logic [1:0][31:0]      req_op1_i,
    input  logic [1:0][31:0]      req_op2_i,
    input  logic [1:0][TAG_W-1:0] req_tag_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_result_o,
    output logic                  rsp_taken_o,
    output logic                  rsp_id_o,
    output logic [TAG_W-1:0]      rsp_tag_o
);

    logic        w_free;
    logic        w_en;
    logic        w_grant;
    logic        w_win;
    logic_req_t  w_req;
    logic_rsp_t  w_rsp;
    logic [31:0] w_result;
    logic        w_taken;

    logic_rsp_t  r_rsp;
    logic        r_rsp_valid;
    logic        r_rr;

    // Winner selection, ready generation and operand mux.
    always_comb begin
        w_free = !r_rsp_valid || rsp_ready_i;
        // Gated by reset so ready reads 0 while the block is held in reset.
        w_en   = rst_n_i && w_free && !flush_i;
        w_win  = r_rr;
        if (req_valid_i == 2'b01) begin
            w_win = 1'b0;
        end else if (req_valid_i == 2'b10) begin
            w_win = 1'b1;
        end
        w_grant     = w_en && (|req_valid_i);
        req_ready_o = '0;
        if (w_grant) begin
            req_ready_o[w_win] = 1'b1;
        end
        w_req.funct     = req_funct_i[w_win];
        w_req.is_branch = req_is_branch_i[w_win];
        w_req.op1       = req_op1_i[w_win];
        w_req.op2       = req_op2_i[w_win];
        w_req.tag       = req_tag_i[w_win];
    end

    logical u_logical (
        .funct_i     (w_req.funct),
        .is_branch_i (w_req.is_branch),
        .op1_i       (w_req.op1),
        .op2_i       (w_req.op2),
        .result_o    (w_result),
        .taken_o     (w_taken)
    );

    // Mask the half of the answer that does not apply to the request kind.
    always_comb begin
        w_rsp.result = w_req.is_branch ? 32'b0 : w_result;
        w_rsp.taken  = w_req.is_branch ? w_taken : 1'b0;
        w_rsp.id     = w_win;
        w_rsp.tag    = w_req.tag;
    end

    // Response stage and round-robin pointer; flush only drops the valid bit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rsp       <= '0;
            r_rsp_valid <= 1'b0;
            r_rr        <= 1'b0;
        end else if (flush_i) begin
            r_rsp_valid <= 1'b0;
        end else if (w_grant) begin
            r_rsp       <= w_rsp;
            r_rsp_valid <= 1'b1;
            r_rr        <= ~w_win;
        end else if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_result_o = r_rsp.result;
    assign rsp_taken_o  = r_rsp.taken;
    assign rsp_id_o     = r_rsp.id;
    assign rsp_tag_o    = r_rsp.tag;

endmodule

// File: tb/tb_logic_arbiter.sv
// Directed, table-driven bench for logic_arbiter.
module tb_logic_arbiter;
    import logic_arbiter_pkg::*;

    typedef struct packed {
        logic [3:0]  funct;
        logic        br;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  tag;
    } p_t;

    typedef struct packed {
        logic [1:0]  valid;
        p_t          p0;
        p_t          p1;
        logic        rdy;
        logic        flush;
        logic [1:0]  e_ready;
        logic        e_valid;
        logic [31:0] e_res;
        logic        e_taken;
        logic        e_id;
        logic [3:0]  e_tag;
    } vec_t;

    localparam int NVEC = 21;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][3:0]  req_funct;
    logic [1:0]       req_br;
    logic [1:0][31:0] req_op1;
    logic [1:0][31:0] req_op2;
    logic [1:0][3:0]  req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_taken;
    logic             rsp_id;
    logic [3:0]       rsp_tag;

    int n_chk  = 0;
    int n_fail = 0;

    vec_t vecs [NVEC];
    p_t   p_idle, p_and, p_or, p_blt, p_bgeu, p_sltu, p_xor, p_undl, p_undb, p_and2;

    logic_arbiter #(.TAG_W(4)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .flush_i         (flush),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_funct_i     (req_funct),
        .req_is_branch_i (req_br),
        .req_op1_i       (req_op1),
        .req_op2_i       (req_op2),
        .req_tag_i       (req_tag),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_result_o    (rsp_result),
        .rsp_taken_o     (rsp_taken),
        .rsp_id_o        (rsp_id),
        .rsp_tag_o       (rsp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic p_t pl(logic [3:0] f, logic b, logic [31:0] a, logic [31:0] c,
                              logic [3:0] t);
        p_t p;
        p.funct = f; p.br = b; p.op1 = a; p.op2 = c; p.tag = t;
        return p;
    endfunction

    function automatic vec_t mk(logic [1:0] v, p_t a, p_t b, logic rdy, logic fl,
                                logic [1:0] er, logic ev, logic [31:0] eres, logic et,
                                logic eid, logic [3:0] etag);
        vec_t x;
        x.valid = v; x.p0 = a; x.p1 = b; x.rdy = rdy; x.flush = fl;
        x.e_ready = er; x.e_valid = ev; x.e_res = eres; x.e_taken = et;
        x.e_id = eid; x.e_tag = etag;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(logic [1:0] v, p_t a, p_t b, logic rdy, logic fl);
        req_valid    = v;
        req_funct[0] = a.funct; req_funct[1] = b.funct;
        req_br[0]    = a.br;    req_br[1]    = b.br;
        req_op1[0]   = a.op1;   req_op1[1]   = b.op1;
        req_op2[0]   = a.op2;   req_op2[1]   = b.op2;
        req_tag[0]   = a.tag;   req_tag[1]   = b.tag;
        rsp_ready    = rdy;
        flush        = fl;
    endtask

    task automatic chk_rsp(string pfx, logic ev, logic [31:0] eres, logic et, logic eid,
                           logic [3:0] etag);
        chk({pfx, " rsp_valid"},  32'(rsp_valid),  32'(ev));
        chk({pfx, " rsp_result"}, rsp_result,      eres);
        chk({pfx, " rsp_taken"},  32'(rsp_taken),  32'(et));
        chk({pfx, " rsp_id"},     32'(rsp_id),     32'(eid));
        chk({pfx, " rsp_tag"},    32'(rsp_tag),    32'(etag));
    endtask

    initial begin
        p_idle = '0;
        p_and  = pl(FUNCT3_AND,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3);
        p_or   = pl(FUNCT3_OR,   1'b0, 32'h0000_00FF, 32'h0000_FF00, 4'd5);
        p_blt  = pl(FUNCT3_BLT,  1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'd9);
        p_bgeu = pl(FUNCT3_BGEU, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 4'd2);
        p_sltu = pl(FUNCT3_SLTU, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 4'd4);
        p_xor  = pl(FUNCT3_XOR,  1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd6);
        p_undl = pl(4'hF,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1);
        p_undb = pl(4'hE,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7);
        p_and2 = pl(FUNCT3_AND,  1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 4'd8);

        //            valid  p0      p1      rdy   fl    ready  v     result         tk    id    tag
        vecs[0]  = mk(2'b01, p_and,  p_idle, 1'b1, 1'b0, 2'b01, 1'b1, 32'hF000_F000, 1'b0, 1'b0, 4'd3);
        vecs[1]  = mk(2'b10, p_idle, p_blt,  1'b1, 1'b0, 2'b10, 1'b1, 32'h0,         1'b1, 1'b1, 4'd9);
        vecs[2]  = mk(2'b11, p_or,   p_blt,  1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0, 4'd5);
        vecs[3]  = mk(2'b11, p_or,   p_blt,  1'b1, 1'b0, 2'b10, 1'b1, 32'h0,         1'b1, 1'b1, 4'd9);
        vecs[4]  = mk(2'b11, p_or,   p_blt,  1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0, 4'd5);
        vecs[5]  = mk(2'b11, p_or,   p_blt,  1'b1, 1'b0, 2'b10, 1'b1, 32'h0,         1'b1, 1'b1, 4'd9);
        vecs[6]  = mk(2'b11, p_or,   p_sltu, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0, 4'd5);
        vecs[7]  = mk(2'b11, p_bgeu, p_sltu, 1'b1, 1'b0, 2'b10, 1'b1, 32'h1,         1'b0, 1'b1, 4'd4);
        vecs[8]  = mk(2'b01, p_bgeu, p_idle, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0,         1'b0, 1'b0, 4'd2);
        // Backpressure: stage full, consumer stalled for three cycles.
        vecs[9]  = mk(2'b11, p_and,  p_blt,  1'b0, 1'b0, 2'b00, 1'b1, 32'h0,         1'b0, 1'b0, 4'd2);
        vecs[10] = mk(2'b11, p_and,  p_blt,  1'b0, 1'b0, 2'b00, 1'b1, 32'h0,         1'b0, 1'b0, 4'd2);
        vecs[11] = mk(2'b11, p_and,  p_blt,  1'b0, 1'b0, 2'b00, 1'b1, 32'h0,         1'b0, 1'b0, 4'd2);
        vecs[12] = mk(2'b11, p_and,  p_blt,  1'b1, 1'b0, 2'b10, 1'b1, 32'h0,         1'b1, 1'b1, 4'd9);
        vecs[13] = mk(2'b01, p_and,  p_idle, 1'b1, 1'b0, 2'b01, 1'b1, 32'hF000_F000, 1'b0, 1'b0, 4'd3);
        // Flush with ready high: flush wins, data held, pointer stays at 1.
        vecs[14] = mk(2'b11, p_xor,  p_blt,  1'b1, 1'b1, 2'b00, 1'b0, 32'hF000_F000, 1'b0, 1'b0, 4'd3);
        vecs[15] = mk(2'b11, p_xor,  p_blt,  1'b1, 1'b0, 2'b10, 1'b1, 32'h0,         1'b1, 1'b1, 4'd9);
        vecs[16] = mk(2'b01, p_xor,  p_idle, 1'b1, 1'b0, 2'b01, 1'b1, 32'hF0F0_0F0F, 1'b0, 1'b0, 4'd6);
        vecs[17] = mk(2'b00, p_idle, p_idle, 1'b1, 1'b0, 2'b00, 1'b0, 32'hF0F0_0F0F, 1'b0, 1'b0, 4'd6);
        vecs[18] = mk(2'b01, p_undl, p_idle, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0,         1'b0, 1'b0, 4'd1);
        vecs[19] = mk(2'b10, p_idle, p_undb, 1'b1, 1'b0, 2'b10, 1'b1, 32'h0,         1'b0, 1'b1, 4'd7);
        vecs[20] = mk(2'b01, p_and2, p_idle, 1'b1, 1'b0, 2'b01, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 4'd8);

        // Reset state, with requests already presented.
        rst_n = 1'b0;
        drive(2'b11, p_and, p_blt, 1'b1, 1'b0);
        #3;
        chk("reset req_ready", 32'(req_ready), 32'(2'b00));
        chk_rsp("reset", 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(2'b00, p_idle, p_idle, 1'b1, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].p0, vecs[i].p1, vecs[i].rdy, vecs[i].flush);
            #1;
            chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
            @(posedge clk);
            #1;
            chk_rsp($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_res, vecs[i].e_taken,
                    vecs[i].e_id, vecs[i].e_tag);
        end

        // Reset mid-operation while full and with the pointer at port 1.
        @(negedge clk);
        drive(2'b11, p_and, p_blt, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset req_ready", 32'(req_ready), 32'(2'b00));
        chk_rsp("midreset", 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postreset req_ready", 32'(req_ready), 32'(2'b01));
        @(posedge clk);
        #1;
        chk_rsp("postreset", 1'b1, 32'hF000_F000, 1'b0, 1'b0, 4'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
